// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: decoded-instruction struct, RV32 opcodes and immediate formats
package decode_stage_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] AMO      = 7'b0101111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef struct packed {
        logic lui, auipc, jal, jalr;
        logic beq, bne, blt, bge, bltu, bgeu;
        logic lb, lh, lw, lbu, lhu, sb, sh, sw;
        logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
        logic add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
        logic fence, fence_i, ecall, ebreak;
        logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
        logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
        logic lr, sc, amoswap, amoadd, amoxor, amoand, amoor, amomin, amomax, amominu, amomaxu;
        logic sret, mret, wfi, sfence_vma;
    } flags_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
        flags_t      f;
        logic        writes_to_reg;
        logic        illegal;
    } instructions;

    function automatic logic [31:0] imm_of(input imm_fmt_e fmt, input logic [31:0] w);
        case (fmt)
            IMM_I:   return {{20{w[31]}}, w[31:20]};
            IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            IMM_U:   return {w[31:12], 12'h000};
            IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_decode.sv
// instr_decode_comb: purely combinational RV32IMA+priv decoder for one raw word
module instr_decode_comb
    import decode_stage_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1,
    parameter bit ENABLE_A = 1'b1,
    parameter bit ENABLE_S = 1'b1
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output instructions dec,
    output logic        illegal
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2, f5;
    logic [11:0] i12;
    logic [7:0] f3h, f3r;
    logic priv;
    flags_t f;
    imm_fmt_e fmt;
    assign {f7, rs2, rs1, f3, rd, opc} = instr;
    assign f5   = instr[31:27];
    assign i12  = instr[31:20];
    assign f3h  = 8'b1 << f3;
    assign f3r  = {f3h[0], f3h[1], f3h[2], f3h[3], f3h[4], f3h[5], f3h[6], f3h[7]};
    assign priv = f3h[0] && rd == 5'd0 && rs1 == 5'd0;
    always_comb begin
        f   = '0;
        fmt = IMM_R;
        case (opc)
            LUI:      begin f.lui = 1'b1; fmt = IMM_U; end
            AUIPC:    begin f.auipc = 1'b1; fmt = IMM_U; end
            JAL:      begin f.jal = 1'b1; fmt = IMM_J; end
            JALR:     begin f.jalr = f3h[0]; fmt = IMM_I; end
            BRANCH: begin
                {f.beq, f.bne, f.blt, f.bge, f.bltu, f.bgeu} = {f3h[0], f3h[1], f3h[4], f3h[5], f3h[6], f3h[7]};
                fmt = IMM_B;
            end
            LOAD: begin
                {f.lb, f.lh, f.lw, f.lbu, f.lhu} = {f3h[0], f3h[1], f3h[2], f3h[4], f3h[5]};
                fmt = IMM_I;
            end
            STORE:    begin {f.sb, f.sh, f.sw} = {f3h[0], f3h[1], f3h[2]}; fmt = IMM_S; end
            OP_IMM: begin
                {f.addi, f.slti, f.sltiu, f.xori, f.ori, f.andi} = {f3h[0], f3h[2], f3h[3], f3h[4], f3h[6], f3h[7]};
                {f.slli, f.srli, f.srai} = {f3h[1] && f7 == 7'h00, f3h[5] && f7 == 7'h00, f3h[5] && f7 == 7'h20};
                fmt = IMM_I;
            end
            OP: begin
                {f.add, f.sll, f.slt, f.sltu, f.xor_op, f.srl, f.or_op, f.and_op} = {8{f7 == 7'h00}} & f3r;
                {f.sub, f.sra} = {2{f7 == 7'h20}} & {f3h[0], f3h[5]};
                {f.mul, f.mulh, f.mulhsu, f.mulhu, f.div, f.divu, f.rem, f.remu} = {8{ENABLE_M && f7 == 7'h01}} & f3r;
            end
            MISC_MEM: begin {f.fence, f.fence_i} = {f3h[0], f3h[1]}; fmt = IMM_I; end
            SYSTEM: begin
                {f.ecall, f.ebreak} = {2{priv}} & {i12 == 12'h000, i12 == 12'h001};
                {f.sret, f.mret, f.wfi} = {3{ENABLE_S && priv}} & {i12 == 12'h102, i12 == 12'h302, i12 == 12'h105};
                f.sfence_vma = ENABLE_S && f3h[0] && rd == 5'd0 && f7 == 7'h09;
                {f.csrrw, f.csrrs, f.csrrc, f.csrrwi, f.csrrsi, f.csrrci} = {f3h[1], f3h[2], f3h[3], f3h[5], f3h[6], f3h[7]};
                fmt = IMM_I;
            end
            AMO: begin
                {f.lr, f.sc, f.amoswap, f.amoadd, f.amoxor, f.amoand, f.amoor, f.amomin, f.amomax, f.amominu, f.amomaxu} =
                    {11{ENABLE_A && f3h[2]}} & {f5 == 5'h02 && rs2 == 5'd0, f5 == 5'h03, f5 == 5'h01, f5 == 5'h00, f5 == 5'h04,
                                                f5 == 5'h0C, f5 == 5'h08, f5 == 5'h10, f5 == 5'h14, f5 == 5'h18, f5 == 5'h1C};
            end
            default: ;
        endcase
    end
    always_comb begin
        illegal           = f == '0 || instr[1:0] != 2'b11;
        dec.pc            = pc;
        dec.rd            = (fmt == IMM_S || fmt == IMM_B) ? 5'd0 : rd;
        dec.rs1           = (fmt == IMM_U || fmt == IMM_J) ? 5'd0 : rs1;
        dec.rs2           = (fmt == IMM_I || fmt == IMM_U || fmt == IMM_J) ? 5'd0 : rs2;
        dec.funct7        = f7;
        dec.imm           = imm_of(fmt, instr);
        dec.f             = illegal ? '0 : f;
        dec.writes_to_reg = !illegal && !(f.beq | f.bne | f.blt | f.bge | f.bltu | f.bgeu | f.sb | f.sh | f.sw |
                                          f.fence | f.fence_i | f.ecall | f.ebreak);
        dec.illegal       = illegal;
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: DEPTH-entry fetch queue feeding a registered RV32 decoder
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b1,
    parameter bit ENABLE_A = 1'b1,
    parameter bit ENABLE_S = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output instructions            out_instr,
    output logic                   out_illegal,
    output logic [31:0]            out_tval,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    logic [31:0] q_pc [DEPTH];
    logic [31:0] q_ins [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic push, load, dec_ill;
    instructions dec;
    assign in_ready  = rstn && !flush && cnt != FULL;
    assign push      = in_valid && in_ready;
    assign load      = cnt != '0 && (!out_valid || out_ready) && !flush;
    assign occupancy = cnt;
    assign rs1       = cnt != '0 ? q_ins[rp][19:15] : 5'd0;
    assign rs2       = cnt != '0 ? q_ins[rp][24:20] : 5'd0;
    instr_decode_comb #(
        .ENABLE_M(ENABLE_M),
        .ENABLE_A(ENABLE_A),
        .ENABLE_S(ENABLE_S)
    ) u_dec (
        .instr  (q_ins[rp]),
        .pc     (q_pc[rp]),
        .dec    (dec),
        .illegal(dec_ill)
    );
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wp]  <= in_pc;
            q_ins[wp] <= in_instr;
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {wp, rp, cnt} <= '0;
            out_valid     <= 1'b0;
            out_illegal   <= 1'b0;
            out_tval      <= '0;
            out_instr     <= '0;
        end else if (flush) begin
            {wp, rp, cnt} <= '0;
            out_valid     <= 1'b0;
        end else begin
            wp  <= wp + AW'(push);
            rp  <= rp + AW'(load);
            cnt <= cnt + CW'(push) - CW'(load);
            if (load) begin
                out_instr   <= dec;
                out_illegal <= dec_ill;
                out_tval    <= q_ins[rp];
                out_valid   <= 1'b1;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed + randomized bench with a mask/match reference decoder and in-order scoreboard
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DEPTH = 4;
    localparam int NF    = $bits(flags_t);
    // {mask, match} per flag, in flags_t declaration order
    localparam logic [63:0] TBL [70] = '{
        64'h0000007F_00000037, 64'h0000007F_00000017, 64'h0000007F_0000006F, 64'h0000707F_00000067,
        64'h0000707F_00000063, 64'h0000707F_00001063, 64'h0000707F_00004063, 64'h0000707F_00005063,
        64'h0000707F_00006063, 64'h0000707F_00007063,
        64'h0000707F_00000003, 64'h0000707F_00001003, 64'h0000707F_00002003, 64'h0000707F_00004003,
        64'h0000707F_00005003, 64'h0000707F_00000023, 64'h0000707F_00001023, 64'h0000707F_00002023,
        64'h0000707F_00000013, 64'h0000707F_00002013, 64'h0000707F_00003013, 64'h0000707F_00004013,
        64'h0000707F_00006013, 64'h0000707F_00007013, 64'hFE00707F_00001013, 64'hFE00707F_00005013,
        64'hFE00707F_40005013,
        64'hFE00707F_00000033, 64'hFE00707F_40000033, 64'hFE00707F_00001033, 64'hFE00707F_00002033,
        64'hFE00707F_00003033, 64'hFE00707F_00004033, 64'hFE00707F_00005033, 64'hFE00707F_40005033,
        64'hFE00707F_00006033, 64'hFE00707F_00007033,
        64'h0000707F_0000000F, 64'h0000707F_0000100F, 64'hFFFFFFFF_00000073, 64'hFFFFFFFF_00100073,
        64'h0000707F_00001073, 64'h0000707F_00002073, 64'h0000707F_00003073, 64'h0000707F_00005073,
        64'h0000707F_00006073, 64'h0000707F_00007073,
        64'hFE00707F_02000033, 64'hFE00707F_02001033, 64'hFE00707F_02002033, 64'hFE00707F_02003033,
        64'hFE00707F_02004033, 64'hFE00707F_02005033, 64'hFE00707F_02006033, 64'hFE00707F_02007033,
        64'hF9F0707F_1000202F, 64'hF800707F_1800202F, 64'hF800707F_0800202F, 64'hF800707F_0000202F,
        64'hF800707F_2000202F, 64'hF800707F_6000202F, 64'hF800707F_4000202F, 64'hF800707F_8000202F,
        64'hF800707F_A000202F, 64'hF800707F_C000202F, 64'hF800707F_E000202F,
        64'hFFFFFFFF_10200073, 64'hFFFFFFFF_30200073, 64'hFFFFFFFF_10500073, 64'hFE007FFF_12000073
    };

    logic clk = 1'b0, rstn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic in_ready, out_valid, out_illegal, nm_in_ready, nm_valid, nm_illegal;
    logic [31:0] out_tval, nm_tval;
    logic [4:0] rs1, rs2, nm_rs1, nm_rs2;
    logic [$clog2(DEPTH):0] occupancy, nm_occ;
    instructions out_instr, nm_instr;

    int checks = 0, errors = 0;
    typedef struct {logic [31:0] pc, w;} exp_t;
    exp_t mq[$];

    always #5 clk = ~clk;

    decode_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_illegal(out_illegal), .out_tval(out_tval),
        .rs1(rs1), .rs2(rs2), .occupancy(occupancy)
    );

    decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1'b0)) dut_nm (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(nm_valid), .out_ready(out_ready),
        .out_instr(nm_instr), .out_illegal(nm_illegal), .out_tval(nm_tval),
        .rs1(nm_rs1), .rs2(nm_rs2), .occupancy(nm_occ)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int match_idx(input logic [31:0] w);
        for (int i = 0; i < NF; i++) if ((w & TBL[i][63:32]) == TBL[i][31:0]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] rand_word(input bit legal);
        int k;
        k = legal ? int'($urandom_range(0, NF - 1)) : int'($urandom_range(0, NF + 19));
        if (k >= NF) return $urandom();
        return ($urandom() & ~TBL[k][63:32]) | TBL[k][31:0];
    endfunction

    task automatic sb_check(input logic [31:0] pc, input logic [31:0] w);
        int idx;
        bit ill, u, j, s, b, r, i;
        logic [NF-1:0] ef;
        logic [31:0] imm;
        idx = match_idx(w);
        ill = idx < 0;
        ef  = '0;
        if (!ill) ef[NF-1-idx] = 1'b1;
        chk("sb_pc", out_instr.pc, pc);
        chk("sb_tval", out_tval, w);
        chk("sb_illegal", out_illegal, ill);
        chk("sb_flags", out_instr.f, ef);
        chk("sb_writes", out_instr.writes_to_reg, !ill && !(idx inside {[4:9], [15:17], [37:40]}));
        if (!ill) begin
            u = w[6:0] inside {7'h37, 7'h17};
            j = w[6:0] == 7'h6F;
            s = w[6:0] == 7'h23;
            b = w[6:0] == 7'h63;
            r = w[6:0] inside {7'h33, 7'h2F};
            i = !(u | j | s | b | r);
            imm = u ? {w[31:12], 12'h000} :
                  j ? 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})) :
                  s ? 32'($signed({w[31:25], w[11:7]})) :
                  b ? 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})) :
                  r ? 32'h0 : 32'($signed(w[31:20]));
            chk("sb_rd", out_instr.rd, (s | b) ? 5'd0 : w[11:7]);
            chk("sb_rs1", out_instr.rs1, (u | j) ? 5'd0 : w[19:15]);
            chk("sb_rs2", out_instr.rs2, (i | u | j) ? 5'd0 : w[24:20]);
            chk("sb_imm", out_instr.imm, imm);
        end
    endtask

    task automatic tick();
        bit hs_in, hs_out, clr;
        exp_t e;
        #1;
        hs_in  = in_valid && in_ready;
        hs_out = rstn && out_valid && out_ready;
        clr    = !rstn || flush;
        if (hs_out) begin
            if (mq.size() == 0) chk("sb_extra_output", out_valid, 1'b0);
            else begin
                e = mq.pop_front();
                sb_check(e.pc, e.w);
            end
        end
        @(posedge clk);
        #1;
        if (clr) mq.delete();
        else if (hs_in) mq.push_back('{in_pc, in_instr});
    endtask

    task automatic push_word(input logic [31:0] pc, input logic [31:0] w);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] w);
        push_word(pc, w);
        tick();
    endtask

    initial begin
        logic [31:0] p;
        p = 32'h8000_1000;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_instr", out_instr == '0, 1'b1);
        chk("rst_out_tval", out_tval, 32'h0);
        chk("rst_occupancy", occupancy, 0);
        rstn = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);

        out_ready = 1'b1;
        push_word(32'h8000_0000, 32'h0050_0093);
        chk("addi_latency_valid", out_valid, 1'b0);
        chk("addi_occupancy", occupancy, 1);
        chk("addi_head_rs1", rs1, 5'd0);
        chk("addi_head_rs2", rs2, 5'd5);
        tick();
        chk("addi_out_valid", out_valid, 1'b1);
        chk("addi_flag", out_instr.f.addi, 1'b1);
        chk("addi_rd", out_instr.rd, 5'd1);
        chk("addi_imm", out_instr.imm, 32'd5);
        chk("addi_wr", out_instr.writes_to_reg, 1'b1);
        chk("addi_illegal", out_illegal, 1'b0);

        issue(32'h8000_0004, 32'hFFDF_F0EF);
        chk("jal_flag", out_instr.f.jal, 1'b1);
        chk("jal_imm", out_instr.imm, 32'hFFFF_FFFC);
        chk("jal_rd", out_instr.rd, 5'd1);
        chk("jal_rs1", out_instr.rs1, 5'd0);
        chk("jal_rs2", out_instr.rs2, 5'd0);

        issue(32'h8000_0008, 32'h0220_81B3);
        chk("mul_flag", out_instr.f.mul, 1'b1);
        chk("nm_mul_valid", nm_valid, 1'b1);
        chk("nm_mul_illegal", nm_illegal, 1'b1);
        chk("nm_mul_flag", nm_instr.f.mul, 1'b0);
        chk("nm_mul_tval", nm_tval, 32'h0220_81B3);

        push_word(32'h8000_000C, 32'h1000_A2AF);
        chk("lr_head_rs1", rs1, 5'd1);
        tick();
        chk("lr_flag", out_instr.f.lr, 1'b1);
        chk("lr_rd", out_instr.rd, 5'd5);
        chk("lr_rs1", out_instr.rs1, 5'd1);

        issue(32'h8000_0010, 32'h0000_0000);
        chk("zero_illegal", out_illegal, 1'b1);
        chk("zero_wr", out_instr.writes_to_reg, 1'b0);
        issue(32'h8000_0014, 32'hFFFF_FFFF);
        chk("ones_illegal", out_illegal, 1'b1);
        chk("ones_instr_illegal", out_instr.illegal, 1'b1);
        chk("ones_wr", out_instr.writes_to_reg, 1'b0);
        chk("ones_pc", out_instr.pc, 32'h8000_0014);
        tick();
        tick();

        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_word(p, rand_word(1'b1));
            p += 4;
        end
        chk("full_occupancy", occupancy, DEPTH);
        in_valid  = 1'b1;
        in_instr  = rand_word(1'b1);
        out_ready = 1'b1;
        #1;
        chk("full_in_ready", in_ready, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("stream_valid", out_valid, 1'b1);
            tick();
        end
        chk("stream_done_valid", out_valid, 1'b0);
        chk("stream_done_occ", occupancy, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(p, rand_word(1'b1));
            p += 4;
        end
        chk("pre_flush_occ", occupancy, 3);
        in_valid = 1'b1;
        in_instr = 32'h0010_0093;
        flush    = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", occupancy, 0);
        chk("flush_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_flush_valid", out_valid, 1'b0);
        end

        for (int c = 0; c < 300; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_pc     = p;
            in_instr  = rand_word(1'b0);
            p += 4;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        chk("random_drained", mq.size(), 0);
        chk("random_idle_valid", out_valid, 1'b0);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_word(p, rand_word(1'b1));
            p += 4;
        end
        rstn = 1'b0;
        tick();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_illegal", out_illegal, 1'b0);
        chk("midrst_tval", out_tval, 32'h0);
        chk("midrst_instr", out_instr == '0, 1'b1);
        chk("midrst_occ", occupancy, 0);
        chk("midrst_rs1", rs1, 5'd0);
        chk("midrst_in_ready", in_ready, 1'b0);
        rstn      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_stale", out_valid, 1'b0);
        end
        issue(32'h8000_2000, 32'h0050_0093);
        chk("post_rst_deliver", out_valid, 1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
